// File: rtl/syncgen_param.sv
// Sync shaper and Z80 raster-interrupt generator: derives HSYNC/VSYNC/composite sync from the CRTC
// and raises INT_N every INT_PERIOD lines, realigned to VSYNC and cleared by ack or irq_reset.
module syncgen_param #(
  parameter int unsigned HSYNC_DELAY = 2,
  parameter int unsigned HSYNC_LEN   = 4,
  parameter int unsigned VSYNC_DELAY = 2,
  parameter int unsigned VSYNC_LEN   = 4,
  parameter int unsigned INT_PERIOD  = 52,
  parameter int unsigned INT_ALIGN   = 2,
  parameter int unsigned INT_VS_MIN  = 32,
  parameter int unsigned ICNT_W      = 6,
  parameter int unsigned LCNT_W      = 5,
  parameter int unsigned SYNC_MODE   = 0
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              CCLK_EN_N,
  input  logic              HSYNC_I,
  input  logic              VSYNC_I,
  input  logic              IORQ_N,
  input  logic              M1_N,
  input  logic              irq_reset,
  output logic              HSYNC_O,
  output logic              VSYNC_O,
  output logic              SYNC_N,
  output logic              INT_N,
  output logic [ICNT_W-1:0] ICNT,
  output logic              LCNT_ACT
);

  localparam int unsigned H_MAX  = HSYNC_DELAY + HSYNC_LEN;
  localparam int unsigned V_MAX  = VSYNC_DELAY + VSYNC_LEN;
  localparam int unsigned HCNT_W = $clog2(H_MAX + 1);

  localparam logic [HCNT_W-1:0] H_DLY_L   = HCNT_W'(HSYNC_DELAY);
  localparam logic [HCNT_W-1:0] H_MAX_L   = HCNT_W'(H_MAX);
  localparam logic [LCNT_W-1:0] V_DLY_L   = LCNT_W'(VSYNC_DELAY);
  localparam logic [LCNT_W-1:0] V_MAX_L   = LCNT_W'(V_MAX);
  localparam logic [LCNT_W-1:0] ALIGN_M1  = LCNT_W'(INT_ALIGN - 1);
  localparam logic [ICNT_W-1:0] PER_M1    = ICNT_W'(INT_PERIOD - 1);
  localparam logic [ICNT_W-1:0] VS_MIN_L  = ICNT_W'(INT_VS_MIN);

  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              ack_q, ack_d;
  logic              int_n_q, int_n_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;

  logic hs_fall, vs_rise, realign, ack_set, ack_rise, int_assert;

  always_comb begin
    hs_d       = HSYNC_I;
    vs_d       = vs_q;
    hcnt_d     = hcnt_q;
    lcnt_d     = lcnt_q;
    icnt_d     = icnt_q;
    int_n_d    = int_n_q;
    int_assert = 1'b0;

    hs_fall = hs_q & ~HSYNC_I;
    vs_rise = VSYNC_I & ~vs_q & CCLK_EN_N;
    if (CCLK_EN_N) vs_d = VSYNC_I;

    // Horizontal tick counter, held at zero outside HSYNC_I
    if (!HSYNC_I) begin
      hcnt_d = '0;
    end else if (CCLK_EN_N && (hcnt_q != H_MAX_L)) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end

    // Line counter since VSYNC_I rise, saturating when the window closes
    if (vs_rise) begin
      lcnt_d = '0;
    end else if (hs_fall && (lcnt_q != V_MAX_L)) begin
      lcnt_d = lcnt_q + LCNT_W'(1);
    end

    realign = hs_fall & (lcnt_q == ALIGN_M1);

    // Ack latch follows one M1 cycle; only its first clk counts
    ack_set  = ~int_n_q & ~IORQ_N & ~M1_N;
    ack_d    = M1_N ? 1'b0 : (ack_q | ack_set);
    ack_rise = ack_set & ~ack_q;

    if (irq_reset) begin
      icnt_d  = '0;
      int_n_d = 1'b1;
    end else if (realign) begin
      if (icnt_q >= VS_MIN_L) begin
        int_n_d    = 1'b0;
        int_assert = 1'b1;
      end
      icnt_d = '0;
    end else if (hs_fall) begin
      if (icnt_q == PER_M1) begin
        icnt_d     = '0;
        int_n_d    = 1'b0;
        int_assert = 1'b1;
      end else begin
        icnt_d = icnt_q + ICNT_W'(1);
      end
    end

    if (ack_rise) begin
      icnt_d[ICNT_W-1] = 1'b0;
      if (!int_assert) int_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      ack_q   <= 1'b0;
      int_n_q <= 1'b1;
      hcnt_q  <= '0;
      lcnt_q  <= V_MAX_L;
      icnt_q  <= '0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ack_q   <= ack_d;
      int_n_q <= int_n_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      icnt_q  <= icnt_d;
    end
  end

  assign HSYNC_O  = HSYNC_I & (hcnt_q >= H_DLY_L) & (hcnt_q < H_MAX_L);
  assign VSYNC_O  = (lcnt_q >= V_DLY_L) & (lcnt_q < V_MAX_L);
  assign LCNT_ACT = (lcnt_q < V_MAX_L);
  assign INT_N    = int_n_q;
  assign ICNT     = icnt_q;

  generate
    if (SYNC_MODE == 0) begin : g_sync_xnor
      assign SYNC_N = ~(HSYNC_O ^ VSYNC_O);
    end else begin : g_sync_nor
      assign SYNC_N = ~(HSYNC_O | VSYNC_O);
    end
  endgenerate

endmodule

// File: tb/tb_syncgen_param.sv
// Directed bench for syncgen_param: interrupt period, ack, VSYNC realign, sync shaping and resets.
module tb_syncgen_param;

  logic       clk = 1'b0;
  logic       RESET_N, CCLK_EN_N, HSYNC_I, VSYNC_I, IORQ_N, M1_N, irq_reset;
  logic       HSYNC_O, VSYNC_O, SYNC_N, INT_N, LCNT_ACT;
  logic [5:0] ICNT;

  int checks = 0;
  int errors = 0;

  syncgen_param dut (
    .clk(clk), .RESET_N(RESET_N), .CCLK_EN_N(CCLK_EN_N), .HSYNC_I(HSYNC_I), .VSYNC_I(VSYNC_I),
    .IORQ_N(IORQ_N), .M1_N(M1_N), .irq_reset(irq_reset), .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O),
    .SYNC_N(SYNC_N), .INT_N(INT_N), .ICNT(ICNT), .LCNT_ACT(LCNT_ACT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One HSYNC_I pulse; returns just after the clk that sees its falling edge
  task automatic hline();
    HSYNC_I = 1'b1;
    tick();
    tick();
    HSYNC_I = 1'b0;
    tick();
  endtask

  task automatic hlines(input int n);
    for (int i = 0; i < n; i++) hline();
  endtask

  task automatic do_reset();
    CCLK_EN_N = 1'b1; HSYNC_I = 1'b0; VSYNC_I = 1'b0;
    IORQ_N = 1'b1; M1_N = 1'b1; irq_reset = 1'b0;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({HSYNC_O, VSYNC_O, SYNC_N, INT_N, LCNT_ACT} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00110", {HSYNC_O, VSYNC_O, SYNC_N, INT_N, LCNT_ACT});
    end
    checks++;
    if (ICNT !== 6'd0) begin
      errors++; $display("FAIL reset_icnt: got %0d expected 0", ICNT);
    end
  endtask

  task automatic test_int_period();
    do_reset();
    hlines(51);
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd51}) begin
      errors++; $display("FAIL period_51: got INT_N=%b ICNT=%0d expected 1/51", INT_N, ICNT);
    end
    hline();
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd0}) begin
      errors++; $display("FAIL period_52: got INT_N=%b ICNT=%0d expected 0/0", INT_N, ICNT);
    end
    hlines(8);
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd8}) begin
      errors++; $display("FAIL period_60: got INT_N=%b ICNT=%0d expected 0/8", INT_N, ICNT);
    end
    IORQ_N = 1'b0; M1_N = 1'b0;
    tick();
    tick();
    IORQ_N = 1'b1; M1_N = 1'b1;
    tick();
    hlines(43);
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd51}) begin
      errors++; $display("FAIL period_103: got INT_N=%b ICNT=%0d expected 1/51", INT_N, ICNT);
    end
    hline();
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd0}) begin
      errors++; $display("FAIL period_104: got INT_N=%b ICNT=%0d expected 0/0", INT_N, ICNT);
    end
  endtask

  task automatic test_ack();
    do_reset();
    hlines(92);
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd40}) begin
      errors++; $display("FAIL ack_pre: got INT_N=%b ICNT=%0d expected 0/40", INT_N, ICNT);
    end
    IORQ_N = 1'b0; M1_N = 1'b0;
    tick();
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd8}) begin
      errors++; $display("FAIL ack_first: got INT_N=%b ICNT=%0d expected 1/8", INT_N, ICNT);
    end
    tick();
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd8}) begin
      errors++; $display("FAIL ack_hold: got INT_N=%b ICNT=%0d expected 1/8", INT_N, ICNT);
    end
    IORQ_N = 1'b1; M1_N = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    // Continues from test_ack: ICNT=8, INT_N=1
    hlines(44);
    hlines(51);
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd51}) begin
      errors++; $display("FAIL b2b_pre: got INT_N=%b ICNT=%0d expected 0/51", INT_N, ICNT);
    end
    HSYNC_I = 1'b1;
    tick();
    tick();
    HSYNC_I = 1'b0; IORQ_N = 1'b0; M1_N = 1'b0;
    tick();
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd0}) begin
      errors++; $display("FAIL b2b_assert_wins: got INT_N=%b ICNT=%0d expected 0/0", INT_N, ICNT);
    end
    tick();
    checks++;
    if (INT_N !== 1'b0) begin
      errors++; $display("FAIL b2b_one_ack_per_m1: got INT_N=%b expected 0", INT_N);
    end
    IORQ_N = 1'b1; M1_N = 1'b1;
    tick();
    IORQ_N = 1'b0; M1_N = 1'b0;
    tick();
    checks++;
    if (INT_N !== 1'b1) begin
      errors++; $display("FAIL b2b_next_m1_ack: got INT_N=%b expected 1", INT_N);
    end
    IORQ_N = 1'b1; M1_N = 1'b1;
    tick();
  endtask

  task automatic test_realign();
    do_reset();
    hlines(35);
    VSYNC_I = 1'b1;
    tick();
    hline();
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd36}) begin
      errors++; $display("FAIL realign_line1: got INT_N=%b ICNT=%0d expected 1/36", INT_N, ICNT);
    end
    hline();
    checks++;
    if ({INT_N, ICNT} !== {1'b0, 6'd0}) begin
      errors++; $display("FAIL realign_hi: got INT_N=%b ICNT=%0d expected 0/0", INT_N, ICNT);
    end
    VSYNC_I = 1'b0;
    IORQ_N = 1'b0; M1_N = 1'b0;
    tick();
    IORQ_N = 1'b1; M1_N = 1'b1;
    tick();
    hlines(20);
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd20}) begin
      errors++; $display("FAIL realign_pre_lo: got INT_N=%b ICNT=%0d expected 1/20", INT_N, ICNT);
    end
    VSYNC_I = 1'b1;
    tick();
    hlines(2);
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd0}) begin
      errors++; $display("FAIL realign_lo: got INT_N=%b ICNT=%0d expected 1/0", INT_N, ICNT);
    end
    VSYNC_I = 1'b0;
    tick();
  endtask

  task automatic test_hsync();
    logic [9:0] obs10;
    logic [2:0] obs3;
    do_reset();
    HSYNC_I = 1'b1;
    for (int i = 0; i < 10; i++) begin
      obs10[i] = HSYNC_O;
      if (i == 9) HSYNC_I = 1'b0;
      tick();
    end
    checks++;
    if (obs10 !== 10'b0000111100) begin
      errors++; $display("FAIL hsync_long: got %b expected 0000111100", obs10);
    end
    HSYNC_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      obs3[i] = HSYNC_O;
      if (i == 2) HSYNC_I = 1'b0;
      tick();
    end
    checks++;
    if (obs3 !== 3'b100) begin
      errors++; $display("FAIL hsync_short: got %b expected 100", obs3);
    end
    HSYNC_I = 1'b1; CCLK_EN_N = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (HSYNC_O !== 1'b0) begin
      errors++; $display("FAIL hsync_cclk_gate: got %b expected 0", HSYNC_O);
    end
    CCLK_EN_N = 1'b1;
    tick();
    tick();
    checks++;
    if (HSYNC_O !== 1'b1) begin
      errors++; $display("FAIL hsync_after_gate: got %b expected 1", HSYNC_O);
    end
    HSYNC_I = 1'b0;
    #1;
    checks++;
    if (HSYNC_O !== 1'b0) begin
      errors++; $display("FAIL hsync_early_end: got %b expected 0", HSYNC_O);
    end
    tick();
  endtask

  task automatic test_vsync();
    logic [5:0] vo, la, sn;
    do_reset();
    VSYNC_I = 1'b1;
    tick();
    checks++;
    if ({VSYNC_O, LCNT_ACT} !== 2'b01) begin
      errors++; $display("FAIL vsync_rise: got VSYNC_O/LCNT_ACT=%b expected 01", {VSYNC_O, LCNT_ACT});
    end
    for (int i = 0; i < 6; i++) begin
      hline();
      vo[i] = VSYNC_O; la[i] = LCNT_ACT; sn[i] = SYNC_N;
    end
    checks++;
    if (vo !== 6'b011110) begin
      errors++; $display("FAIL vsync_window: got %b expected 011110", vo);
    end
    checks++;
    if (la !== 6'b011111) begin
      errors++; $display("FAIL lcnt_act_window: got %b expected 011111", la);
    end
    checks++;
    if (sn !== 6'b100001) begin
      errors++; $display("FAIL sync_n_vsync: got %b expected 100001", sn);
    end
    VSYNC_I = 1'b0;
    tick();
    CCLK_EN_N = 1'b0; VSYNC_I = 1'b1;
    tick();
    tick();
    checks++;
    if (LCNT_ACT !== 1'b0) begin
      errors++; $display("FAIL vsync_cclk_gate: got %b expected 0", LCNT_ACT);
    end
    CCLK_EN_N = 1'b1;
    tick();
    checks++;
    if (LCNT_ACT !== 1'b1) begin
      errors++; $display("FAIL vsync_cclk_rise: got %b expected 1", LCNT_ACT);
    end
    hlines(3);
    checks++;
    if (VSYNC_O !== 1'b1) begin
      errors++; $display("FAIL vsync_mid: got %b expected 1", VSYNC_O);
    end
    VSYNC_I = 1'b0;
    tick();
    VSYNC_I = 1'b1;
    tick();
    checks++;
    if ({VSYNC_O, LCNT_ACT} !== 2'b01) begin
      errors++; $display("FAIL vsync_restart: got VSYNC_O/LCNT_ACT=%b expected 01", {VSYNC_O, LCNT_ACT});
    end
    hlines(2);
    checks++;
    if (VSYNC_O !== 1'b1) begin
      errors++; $display("FAIL vsync_restart_on: got %b expected 1", VSYNC_O);
    end
    VSYNC_I = 1'b0;
    tick();
  endtask

  task automatic test_irq_reset_and_reset();
    do_reset();
    hlines(51);
    HSYNC_I = 1'b1;
    tick();
    tick();
    HSYNC_I = 1'b0; irq_reset = 1'b1;
    tick();
    irq_reset = 1'b0;
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd0}) begin
      errors++; $display("FAIL irq_reset_wins: got INT_N=%b ICNT=%0d expected 1/0", INT_N, ICNT);
    end
    hline();
    checks++;
    if ({INT_N, ICNT} !== {1'b1, 6'd1}) begin
      errors++; $display("FAIL irq_reset_after: got INT_N=%b ICNT=%0d expected 1/1", INT_N, ICNT);
    end
    VSYNC_I = 1'b1;
    tick();
    hlines(3);
    checks++;
    if ({HSYNC_O, VSYNC_O, SYNC_N} !== 3'b010) begin
      errors++; $display("FAIL sync_n_v_only: got H/V/SYNC_N=%b expected 010", {HSYNC_O, VSYNC_O, SYNC_N});
    end
    HSYNC_I = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if ({HSYNC_O, VSYNC_O, SYNC_N} !== 3'b111) begin
      errors++; $display("FAIL sync_n_both: got H/V/SYNC_N=%b expected 111", {HSYNC_O, VSYNC_O, SYNC_N});
    end
    RESET_N = 1'b0;
    tick();
    checks++;
    if ({HSYNC_O, VSYNC_O, SYNC_N, INT_N, LCNT_ACT, ICNT} !== {5'b00110, 6'd0}) begin
      errors++;
      $display("FAIL reset_mid_vsync: got %b expected 00110000000",
               {HSYNC_O, VSYNC_O, SYNC_N, INT_N, LCNT_ACT, ICNT});
    end
    RESET_N = 1'b1; HSYNC_I = 1'b0; VSYNC_I = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_int_period();
    test_ack();
    test_back_to_back();
    test_realign();
    test_hsync();
    test_vsync();
    test_irq_reset_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
